// File: rtl/note_scheduler_pkg.sv
// note_pkg: shared state enum, store depth and note entry layout for note_scheduler
package note_pkg;
  localparam int DEPTH = 16;
  localparam int NOTE_W = 4;
  localparam int DUR_W = 2;
  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;
  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0] dur;
  } entry_t;
endpackage

// File: rtl/note_scheduler_if.sv
// note_scheduler_if: record/control/live inputs and tone/status outputs of note_scheduler
interface note_scheduler_if;
  import note_pkg::*;
  logic rec_valid;
  logic [NOTE_W-1:0] rec_note;
  logic [DUR_W-1:0] rec_dur;
  logic clear;
  logic play_start;
  logic play_stop;
  logic live_valid;
  logic [NOTE_W-1:0] live_note;
  logic tone_en;
  logic [NOTE_W-1:0] tone_note;
  logic busy;
  logic [4:0] count;
  logic full;
  logic [3:0] play_idx;
  logic done;
  modport master(
    output rec_valid, rec_note, rec_dur, clear, play_start, play_stop, live_valid, live_note,
    input tone_en, tone_note, busy, count, full, play_idx, done
  );
  modport slave(
    input rec_valid, rec_note, rec_dur, clear, play_start, play_stop, live_valid, live_note,
    output tone_en, tone_note, busy, count, full, play_idx, done
  );
endinterface

// File: rtl/note_scheduler_beat_tick_gen.sv
// beat_tick_gen: loadable down-counter pulsing tick at zero every TICK_DIV enabled cycles
module beat_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(TICK_DIV);
  logic [W-1:0] cnt;
  assign tick = en && cnt == '0;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (load || tick) cnt <= W'(TICK_DIV - 1);
    else if (en) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: 16-note record/playback sequencer and tone arbiter, NOTE_SCHED_LOOP_EN repeats playback
module note_scheduler import note_pkg::*; #(
  parameter int TICK_DIV = 25000000
) (
  input logic clk,
  input logic reset,
  note_scheduler_if.slave bus
);
  state_t state, state_n;
  logic [4:0] count, count_n;
  logic [3:0] idx, idx_n;
  logic [NOTE_W-1:0] cur_note, cur_note_n, tone_note, tone_note_n;
  logic [DUR_W-1:0] dur, dur_n;
  logic tone_en, tone_en_n, done, done_n, wr, tick, full, last, stay_idle;
  entry_t mem [DEPTH];
  entry_t rd;
  beat_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk), .reset(reset), .load(state == FETCH), .en(state == PLAY), .tick(tick)
  );
  assign rd = mem[idx];
  assign full = count == 5'(DEPTH);
  assign last = {1'b0, idx} == count - 5'd1;
  assign wr = !bus.clear && state == IDLE && bus.rec_valid && !full;
  assign stay_idle = state == IDLE && state_n == IDLE;
  always_comb begin
    state_n = state;
    idx_n = idx;
    cur_note_n = cur_note;
    dur_n = dur;
    done_n = 1'b0;
    count_n = wr ? count + 5'd1 : count;
    if (bus.clear) begin
      state_n = IDLE;
      count_n = '0;
      idx_n = '0;
    end else if (state != IDLE && bus.play_stop) begin
      state_n = IDLE;
    end else if (state == IDLE) begin
      if (bus.play_start && count != '0) begin
        state_n = FETCH;
        idx_n = '0;
      end
    end else if (state == FETCH) begin
      state_n = PLAY;
      cur_note_n = rd.note;
      dur_n = rd.dur;
    end else if (tick) begin
      if (dur != '0) begin
        dur_n = dur - 1'b1;
      end else if (!last) begin
        state_n = FETCH;
        idx_n = idx + 4'd1;
      end else begin
        done_n = 1'b1;
`ifdef NOTE_SCHED_LOOP_EN
        state_n = FETCH;
        idx_n = '0;
`else
        state_n = IDLE;
`endif
      end
    end
    tone_en_n = state_n == PLAY || (stay_idle && bus.live_valid);
    tone_note_n = state_n == PLAY ? cur_note_n : stay_idle ? bus.live_note : tone_note;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      idx <= '0;
      cur_note <= '0;
      dur <= '0;
      tone_en <= 1'b0;
      tone_note <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      idx <= idx_n;
      cur_note <= cur_note_n;
      dur <= dur_n;
      tone_en <= tone_en_n;
      tone_note <= tone_note_n;
      done <= done_n;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[count[3:0]] <= {bus.rec_note, bus.rec_dur};
  end
  assign bus.tone_en = tone_en;
  assign bus.tone_note = tone_note;
  assign bus.busy = state != IDLE;
  assign bus.count = count;
  assign bus.full = full;
  assign bus.play_idx = idx;
  assign bus.done = done;
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed vector table plus playback, stop, clear, full and loop sequences
module tb_note_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  note_scheduler_if bus();
  note_scheduler #(.TICK_DIV(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic rv;
    logic [3:0] rn;
    logic [1:0] rd;
    logic clr;
    logic lv;
    logic [3:0] ln;
    logic [4:0] cnt;
    logic fl;
    logic te;
    logic [3:0] tn;
  } vec_t;
  vec_t vt [9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic rec(input logic [3:0] n, input logic [1:0] d);
    bus.rec_valid = 1'b1;
    bus.rec_note = n;
    bus.rec_dur = d;
    step();
    bus.rec_valid = 1'b0;
  endtask
  task automatic start();
    bus.play_start = 1'b1;
    step();
    bus.play_start = 1'b0;
  endtask
  initial begin
    logic [3:0] nn [3];
    logic [1:0] dd [3];
    logic exp_te [27];
    logic [3:0] exp_tn [27];
    logic [3:0] exp_idx [27];
    int j, dones, seen_note;
    bit got_done;
    bus.rec_valid = 0; bus.rec_note = 0; bus.rec_dur = 0; bus.clear = 0;
    bus.play_start = 0; bus.play_stop = 0; bus.live_valid = 0; bus.live_note = 0;
    vt[0] = '{0, 0, 0, 0, 1, 9, 0, 0, 1, 9};
    vt[1] = '{0, 0, 0, 0, 0, 9, 0, 0, 0, 9};
    vt[2] = '{1, 3, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[3] = '{1, 5, 1, 0, 0, 0, 2, 0, 0, 0};
    vt[4] = '{1, 7, 2, 0, 1, 2, 3, 0, 1, 2};
    vt[5] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    vt[6] = '{1, 3, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[7] = '{1, 5, 1, 0, 0, 0, 2, 0, 0, 0};
    vt[8] = '{1, 7, 2, 0, 0, 0, 3, 0, 0, 0};
    repeat (2) step();
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_tone_en", 32'(bus.tone_en), 0);
    chk("reset_tone_note", 32'(bus.tone_note), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_idx", 32'(bus.play_idx), 0);
    chk("reset_full", 32'(bus.full), 0);
    reset = 1'b0;
    foreach (vt[i]) begin
      bus.rec_valid = vt[i].rv; bus.rec_note = vt[i].rn; bus.rec_dur = vt[i].rd;
      bus.clear = vt[i].clr; bus.live_valid = vt[i].lv; bus.live_note = vt[i].ln;
      step();
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vt[i].cnt));
      chk($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vt[i].fl));
      chk($sformatf("vec%0d_tone_en", i), 32'(bus.tone_en), 32'(vt[i].te));
      chk($sformatf("vec%0d_tone_note", i), 32'(bus.tone_note), 32'(vt[i].tn));
    end
    bus.rec_valid = 0; bus.clear = 0; bus.live_valid = 0;
    nn = '{4'd3, 4'd5, 4'd7};
    dd = '{2'd0, 2'd1, 2'd2};
    j = 0;
    for (int n = 0; n < 3; n++) begin
      exp_te[j] = 0; exp_tn[j] = 0; exp_idx[j] = 4'(n); j++;
      for (int c = 0; c < (int'(dd[n]) + 1) * 4; c++) begin
        exp_te[j] = 1; exp_tn[j] = nn[n]; exp_idx[j] = 4'(n); j++;
      end
    end
    bus.live_valid = 1; bus.live_note = 9;
    start();
    for (int k = 0; k < 27; k++) begin
      chk($sformatf("play%0d_busy", k), 32'(bus.busy), 1);
      chk($sformatf("play%0d_tone_en", k), 32'(bus.tone_en), 32'(exp_te[k]));
      if (exp_te[k]) chk($sformatf("play%0d_tone_note", k), 32'(bus.tone_note), 32'(exp_tn[k]));
      chk($sformatf("play%0d_idx", k), 32'(bus.play_idx), 32'(exp_idx[k]));
      chk($sformatf("play%0d_done", k), 32'(bus.done), 0);
      bus.rec_valid = k == 5;
      bus.play_start = k == 10;
      step();
    end
    bus.rec_valid = 0; bus.play_start = 0;
    chk("end_done", 32'(bus.done), 1);
    chk("end_tone_en", 32'(bus.tone_en), 0);
    chk("end_count", 32'(bus.count), 3);
`ifdef NOTE_SCHED_LOOP_EN
    chk("end_busy", 32'(bus.busy), 1);
    chk("end_idx", 32'(bus.play_idx), 0);
    bus.play_stop = 1; step(); bus.play_stop = 0;
    chk("loop_stop_busy", 32'(bus.busy), 0);
`else
    chk("end_busy", 32'(bus.busy), 0);
    step();
    chk("after_done", 32'(bus.done), 0);
    chk("after_live_en", 32'(bus.tone_en), 1);
    chk("after_live_note", 32'(bus.tone_note), 9);
`endif
    bus.live_valid = 0;
    step();
    start();
    step(); step();
    chk("stop_pre_tone_en", 32'(bus.tone_en), 1);
    chk("stop_pre_busy", 32'(bus.busy), 1);
    bus.play_stop = 1; step(); bus.play_stop = 0;
    chk("stop_busy", 32'(bus.busy), 0);
    chk("stop_tone_en", 32'(bus.tone_en), 0);
    dones = 32'(bus.done);
    repeat (8) begin step(); dones += 32'(bus.done); end
    chk("stop_no_done", 32'(dones), 0);
    chk("stop_busy_after", 32'(bus.busy), 0);
    bus.play_stop = 1; step(); bus.play_stop = 0;
    chk("stop_idle_count", 32'(bus.count), 3);
    start();
    repeat (3) step();
    chk("clr_pre_busy", 32'(bus.busy), 1);
    bus.clear = 1; step(); bus.clear = 0;
    chk("clr_busy", 32'(bus.busy), 0);
    chk("clr_count", 32'(bus.count), 0);
    chk("clr_tone_en", 32'(bus.tone_en), 0);
    chk("clr_done", 32'(bus.done), 0);
    chk("clr_idx", 32'(bus.play_idx), 0);
    start();
    chk("empty_busy", 32'(bus.busy), 0);
    chk("empty_done", 32'(bus.done), 0);
    step();
    chk("empty_busy2", 32'(bus.busy), 0);
    chk("empty_done2", 32'(bus.done), 0);
    for (int i = 0; i < 17; i++) rec(i == 16 ? 4'hA : 4'(i), i == 16 ? 2'd3 : 2'd0);
    chk("full_count", 32'(bus.count), 16);
    chk("full_flag", 32'(bus.full), 1);
    start();
    got_done = 0;
    seen_note = -1;
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (bus.play_idx == 4'd15 && bus.tone_en) seen_note = int'(bus.tone_note);
      got_done = bus.done;
      step();
    end
    chk("full_entry15", 32'(seen_note), 15);
    chk("full_done_seen", 32'(got_done), 1);
    bus.clear = 1; step(); bus.clear = 0;
    chk("full_clear_count", 32'(bus.count), 0);
`ifdef NOTE_SCHED_LOOP_EN
    rec(4'd1, 2'd0);
    rec(4'd2, 2'd0);
    start();
    for (int k = 0; k <= 30; k++) begin
      chk($sformatf("loop%0d_idx", k), 32'(bus.play_idx), 32'((k / 5) % 2));
      chk($sformatf("loop%0d_done", k), 32'(bus.done), 32'(k > 0 && k % 10 == 0));
      chk($sformatf("loop%0d_tone_en", k), 32'(bus.tone_en), 32'(k % 5 != 0));
      step();
    end
    bus.play_stop = 1; step(); bus.play_stop = 0;
    chk("loop_end_busy", 32'(bus.busy), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_scheduler.md
# note_scheduler

Playback sequencer and tone-generator arbiter for the music device. Records up to 16 notes with per-note durations into an internal store, replays them in order at a tempo set by a beat-tick divider, and arbitrates the single tone-generator input between sequenced playback and the live keyboard monitor. Sits between the key/switch input logic and the tone generator.

## Interface
- TICK_DIV, 25000000, clk cycles per beat tick (≥2)
- NOTE_W, 4, note code width
- DUR_W, 2, duration field width; stored value d plays for d+1 ticks
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rec_valid  in  1  one-cycle pulse: append {rec_note, rec_dur}
- rec_note  in  NOTE_W  note to record
- rec_dur  in  DUR_W  duration to record
- clear  in  1  pulse: empty store, abort playback
- play_start  in  1  pulse: begin playback at index 0
- play_stop  in  1  pulse: abort playback
- live_valid  in  1  level: live key held
- live_note  in  NOTE_W  live key code
- tone_en  out  1  tone generator enable (registered)
- tone_note  out  NOTE_W  note to sound (registered)
- busy  out  1  high in FETCH or PLAY
- count  out  5  notes stored, 0..16
- full  out  1  count == 16
- play_idx  out  4  index being played
- done  out  1  one-cycle pulse on normal end of sequence

## Operation
- States: IDLE, FETCH, PLAY. Reset → IDLE; count=0, play_idx=0, all outputs 0.
- IDLE: tone_en/tone_note follow live_valid/live_note, one cycle late. rec_valid with !full writes entry[count], count+1. rec_valid when full: dropped.
- IDLE + play_start with count>0 → FETCH, play_idx=0. With count==0: ignored, no done.
- FETCH (1 cycle): latch entry[play_idx] into cur_note/cur_dur, load tick counter with TICK_DIV-1, duration counter with cur_dur; tone_en=0 (articulation gap). → PLAY.
- PLAY: tone_en=1, tone_note=cur_note. Tick fires when tick counter hits 0 (then reloads). On a tick with duration counter 0: note ends. Otherwise decrement duration counter.
- Note end: if play_idx < count-1 → play_idx+1, FETCH. Else last note → IDLE, done=1 for one cycle (loop behaviour: see Configuration).
- While busy: rec_valid ignored, live input ignored, play_start ignored.
- play_stop while busy → IDLE next cycle, tone_en=0, no done. play_stop in IDLE: no effect.
- clear (any state) → count=0, play_idx=0, IDLE, no done.
- Priority same cycle: reset > clear > play_stop > rec_valid/play_start.
- Beat tick generated only while in PLAY; counter free-runs nowhere else.

## Timing
- play_start sampled at edge k → FETCH after k → PLAY after k+1; tone_en rises after edge k+1.
- Each note: 1 FETCH cycle + (d+1)·TICK_DIV PLAY cycles.
- done asserted the cycle state returns to IDLE; tone_en low same cycle.
- Live monitor latency: 1 cycle. First IDLE cycle after playback reflects live inputs sampled that cycle (visible next).
- rec_valid: count updates the following cycle; full combinational from count.

## Configuration
- NOTE_SCHED_LOOP_EN defined: after last note's end → FETCH at play_idx=0, done pulses once per pass, playback continues until play_stop or clear.
- Undefined: last note end → IDLE with done pulse (default).

## Structure
- Shared package note_pkg: state enum (IDLE/FETCH/PLAY), DEPTH=16 constant, note entry struct {note, dur}.
- Sub-module beat_tick_gen: loadable down-counter, TICK_DIV param, load and enable inputs, tick output pulse at 0.
- Store: 16-entry register array inside note_scheduler; read registered in FETCH.

## Test plan (TICK_DIV=4, NOTE_W=4, DUR_W=2)
- Record {3,0},{5,1},{7,2}, play_start → tone_note 3 for 4 cycles, gap, 5 for 8, gap, 7 for 12, then done pulse, busy=0; total 27 cycles.
- 17 rec_valid pulses → count=16, full=1, 17th dropped; entry[15] unchanged.
- play_start with count=0 → stays IDLE, busy=0, no done; live_valid=1 note 9 → tone_en=1, tone_note=9 one cycle later.
- Mid-note play_stop → IDLE next cycle, tone_en=0, no done; rec_valid during playback → count unchanged.
- clear and rec_valid same cycle in IDLE → count=0; clear during PLAY → IDLE, count=0.
- With NOTE_SCHED_LOOP_EN, 2 notes → index sequence 0,1,0,1…, done each pass until play_stop.
